// File: rtl/lstm_h_writeback_pkg.sv
// rtl/lstm_h_writeback_pkg.sv - shared LSTM types and default widths
//
// Purpose: shared LSTM package. It holds the LSTM packet typedef, the
// write-back FSM state enum and the default h/c widths.
// Configuration: defines the H_NUM macro (node count, default 4) when the
// build does not supply one.
// Ports: none (package).

`ifndef H_NUM
`define H_NUM 4
`endif

package lstm_h_writeback_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_OW = 8;

  typedef struct packed {
    logic [DEF_DW-1:0] data;
    logic [7:0]        node;
    logic              last;
  } lstm_pkt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

endpackage

// File: rtl/lstm_sat_trunc.sv
// rtl/lstm_sat_trunc.sv - signed DW to OW narrowing (saturate or wrap)
//
// Purpose: narrows one signed fixed-point h element for streaming.
// Configuration: LSTM_WB_SAT_EN defined -> clamp to [-2^(OW-1), 2^(OW-1)-1];
// undefined -> keep the low OW bits (two's-complement wrap).
// Ports:
//   value  - signed DW-bit input element
//   result - signed OW-bit converted element
// DW must be greater than OW.

module lstm_sat_trunc #(
  parameter int DW = 16,
  parameter int OW = 8
) (
  input  logic [DW-1:0] value,
  output logic [OW-1:0] result
);

`ifdef LSTM_WB_SAT_EN
  localparam logic signed [DW-1:0] MAX_V = {{(DW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V = {{(DW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [DW-1:0] value_s;
  assign value_s = value;

  always_comb begin
    result = value_s[OW-1:0];
    if (value_s > MAX_V) begin
      result = MAX_V[OW-1:0];
    end else if (value_s < MIN_V) begin
      result = MIN_V[OW-1:0];
    end
  end
`else
  // Upper bits are intentionally discarded in wrap mode.
  logic unused_hi;
  assign unused_hi = ^value[DW-1:OW];
  assign result    = value[OW-1:0];
`endif

endmodule

// File: rtl/lstm_h_writeback.sv
// rtl/lstm_h_writeback.sv - LSTM hidden-state capture, feedback and stream-out
//
// Purpose: captures one timestep of node outputs, feeds h/c back at full
// width as the recurrent state, and streams the h vector out one narrowed
// element per handshake.
// Configuration: LSTM_WB_SAT_EN selects saturating narrowing (see
// lstm_sat_trunc); the default build wraps.
// Ports:
//   clock, reset         - rising-edge clock, synchronous active-low reset
//   seq_start            - new sequence: zero recu_h/recu_c/step_cnt
//   cap_valid, cap_ready - capture handshake for h_in/c_in
//   h_in, c_in           - node i at bits [i*DW +: DW]
//   recu_h, recu_c       - registered recurrent state (full DW)
//   out_data/out_valid/out_ready/out_last - element stream, last = node H_NUM-1
//   step_cnt             - timesteps captured since seq_start (wraps)

module lstm_h_writeback
  import lstm_h_writeback_pkg::*;
#(
  parameter int H_NUM = `H_NUM,
  parameter int DW    = DEF_DW,
  parameter int OW    = DEF_OW
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                seq_start,
  input  logic                cap_valid,
  output logic                cap_ready,
  input  logic [H_NUM*DW-1:0] h_in,
  input  logic [H_NUM*DW-1:0] c_in,
  output logic [H_NUM*DW-1:0] recu_h,
  output logic [H_NUM*DW-1:0] recu_c,
  output logic [OW-1:0]       out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [15:0]         step_cnt
);

  localparam int             IW       = (H_NUM > 1) ? $clog2(H_NUM) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(H_NUM - 1);

  wb_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [H_NUM*DW-1:0]  buf_q;
  logic [H_NUM*DW-1:0]  recu_h_q, recu_c_q;
  logic [15:0]          step_q;
  logic                 capture, xfer;
  logic [DW-1:0]        elem;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cap_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    capture   = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (cap_valid) begin
          capture = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (idx_q == LAST_IDX);
        xfer      = out_ready;
        if (out_ready && out_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The stream buffer is separate from recu_* so that seq_start can clear
  // the recurrent state without disturbing a drain already in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q    <= '0;
      buf_q    <= '0;
      recu_h_q <= '0;
      recu_c_q <= '0;
      step_q   <= '0;
    end else begin
      if (capture) begin
        buf_q    <= h_in;
        recu_h_q <= h_in;
        recu_c_q <= c_in;
        idx_q    <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + IW'(1);
      end

      // A capture coinciding with seq_start counts as step 1 of the new sequence.
      if (capture && seq_start) begin
        step_q <= 16'd1;
      end else if (seq_start) begin
        recu_h_q <= '0;
        recu_c_q <= '0;
        step_q   <= '0;
      end else if (capture) begin
        step_q <= step_q + 16'd1;
      end
    end
  end

  assign elem = buf_q[idx_q*DW +: DW];

  lstm_sat_trunc #(
    .DW (DW),
    .OW (OW)
  ) u_conv (
    .value  (elem),
    .result (out_data)
  );

  assign recu_h   = recu_h_q;
  assign recu_c   = recu_c_q;
  assign step_cnt = step_q;

endmodule

// File: tb/tb_lstm_h_writeback.sv
// tb/tb_lstm_h_writeback.sv - scoreboard bench for lstm_h_writeback

module tb_lstm_h_writeback;

  localparam int H  = 4;
  localparam int DW = 16;
  localparam int OW = 8;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset, seq_start, cap_valid, cap_ready;
  logic [H*DW-1:0] h_in, c_in, recu_h, recu_c;
  logic [OW-1:0]   out_data;
  logic            out_valid, out_ready, out_last;
  logic [15:0]     step_cnt;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          stall_prev = 1'b0;
  logic [OW-1:0] data_prev;
  logic          last_prev;

  lstm_h_writeback #(.H_NUM(H), .DW(DW), .OW(OW)) dut (
    .clock     (clock),
    .reset     (reset),
    .seq_start (seq_start),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .h_in      (h_in),
    .c_in      (c_in),
    .recu_h    (recu_h),
    .recu_c    (recu_c),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .step_cnt  (step_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [H*DW-1:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                            input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic push(input logic [OW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops one expectation per handshake; also checks hold-stability
  // on the cycle after a stall.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      if (stall_prev) begin
        check("stall_hold_data", 64'(out_data), 64'(data_prev));
        check("stall_hold_last", 64'(out_last), 64'(last_prev));
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_xfer: got data %0h with no expected element", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("xfer_data", 64'(out_data), 64'(e.data));
          check("xfer_last", 64'(out_last), 64'(e.last));
        end
      end
    end
    stall_prev = reset && out_valid && !out_ready;
    data_prev  = out_data;
    last_prev  = out_last;
  end

  logic [H*DW-1:0] hx, hy, hz;
  logic [OW-1:0]   e0, e1;

  initial begin
    reset = 1'b0; seq_start = 1'b0; cap_valid = 1'b0; out_ready = 1'b1;
    h_in = '0; c_in = '0;
    repeat (3) cyc();

    // Reset state
    check("rst_cap_ready", 64'(cap_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_recu_h",    64'(recu_h),    64'd0);
    check("rst_recu_c",    64'(recu_c),    64'd0);
    check("rst_step_cnt",  64'(step_cnt),  64'd0);
    reset = 1'b1;
    cyc();

    // Basic drain 1,2,3,4 at full rate
    h_in = pack4(16'd1, 16'd2, 16'd3, 16'd4);
    c_in = h_in ^ {H{16'h5555}};
    push(8'd1, 1'b0); push(8'd2, 1'b0); push(8'd3, 1'b0); push(8'd4, 1'b1);
    cap_valid = 1'b1;
    cyc();
    cap_valid = 1'b0;
    check("t1_first_valid", 64'(out_valid), 64'd1);
    check("t1_cap_ready_drain", 64'(cap_ready), 64'd0);
    check("t1_recu_h", 64'(recu_h), 64'(pack4(16'd1, 16'd2, 16'd3, 16'd4)));
    check("t1_recu_c", 64'(recu_c), 64'(pack4(16'd1, 16'd2, 16'd3, 16'd4) ^ {H{16'h5555}}));
    check("t1_step_cnt", 64'(step_cnt), 64'd1);
    repeat (4) cyc();
    check("t1_cap_ready_back", 64'(cap_ready), 64'd1);
    check("t1_valid_low", 64'(out_valid), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Stall pattern 1,0,0,1 mid-drain
    h_in = pack4(16'd5, 16'd6, 16'd7, 16'd8);
    push(8'd5, 1'b0); push(8'd6, 1'b0); push(8'd7, 1'b0); push(8'd8, 1'b1);
    cap_valid = 1'b1;
    cyc();
    cap_valid = 1'b0;
    out_ready = 1'b1; cyc();
    out_ready = 1'b0; cyc();
    out_ready = 1'b0; cyc();
    out_ready = 1'b1;
    repeat (3) cyc();
    check("t2_done", 64'(cap_ready), 64'd1);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    check("t2_step_cnt", 64'(step_cnt), 64'd2);

    // Conversion boundaries, captured together with seq_start
`ifdef LSTM_WB_SAT_EN
    e0 = 8'h7F; e1 = 8'h80;
`else
    e0 = 8'h90; e1 = 8'h00;
`endif
    h_in = pack4(16'h0190, 16'hFE00, 16'h007F, 16'hFF80);
    push(e0, 1'b0); push(e1, 1'b0); push(8'h7F, 1'b0); push(8'h80, 1'b1);
    cap_valid = 1'b1; seq_start = 1'b1;
    cyc();
    cap_valid = 1'b0; seq_start = 1'b0;
    check("t3_recu_h", 64'(recu_h), 64'(pack4(16'h0190, 16'hFE00, 16'h007F, 16'hFF80)));
    check("t3_step_cnt", 64'(step_cnt), 64'd1);
    repeat (4) cyc();
    check("t3_sb_empty", 64'(sb.size()), 64'd0);

    // cap_valid held through a drain: no recapture until IDLE
    hx = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
    hy = pack4(16'h000A, 16'h000B, 16'h000C, 16'h000D);
    h_in = hx;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    push(8'h0A, 1'b0); push(8'h0B, 1'b0); push(8'h0C, 1'b0); push(8'h0D, 1'b1);
    cap_valid = 1'b1;
    cyc();
    h_in = hy;
    for (int i = 0; i < 4; i++) begin
      check("t4_recu_h_hold", 64'(recu_h), 64'(hx));
      cyc();
    end
    check("t4_idle_again", 64'(cap_ready), 64'd1);
    check("t4_step_mid", 64'(step_cnt), 64'd2);
    cyc();
    cap_valid = 1'b0;
    check("t4_recu_h_new", 64'(recu_h), 64'(hy));
    check("t4_step_cnt", 64'(step_cnt), 64'd3);
    repeat (4) cyc();
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // seq_start alone
    seq_start = 1'b1;
    cyc();
    seq_start = 1'b0;
    check("t5_recu_h", 64'(recu_h), 64'd0);
    check("t5_recu_c", 64'(recu_c), 64'd0);
    check("t5_step_cnt", 64'(step_cnt), 64'd0);

    // Reset at the second element of a drain
    hz = pack4(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    h_in = hz;
    push(8'h21, 1'b0);
    cap_valid = 1'b1;
    cyc();
    cap_valid = 1'b0;
    cyc();
    check("t6_second_elem", 64'(out_data), 64'h22);
    reset = 1'b0; out_ready = 1'b0;
    cyc();
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_cap_ready", 64'(cap_ready), 64'd1);
    check("t6_last", 64'(out_last), 64'd0);
    check("t6_data", 64'(out_data), 64'd0);
    check("t6_recu_h", 64'(recu_h), 64'd0);
    check("t6_step_cnt", 64'(step_cnt), 64'd0);
    reset = 1'b1; out_ready = 1'b1;
    repeat (5) cyc();
    check("t6_no_more_valid", 64'(out_valid), 64'd0);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
